frame_serializer: RTL and testbench

- Upstream stage of the ASK/FSK transmitter. Turns a parallel message word into the serial bit stream that drives the modulator's carrier select and ASK gate.
- On a rising edge of `send` it latches the message and emits a fixed frame: preamble, data bits MSB first, optional parity bit, then a guard bit.
- Bit period is programmable in clock cycles. The block provides status outputs for the control logic.

---
 rtl/frame_serializer_if.sv | 23 ++
 rtl/frame_serializer.sv | 132 +++++++++++++
 tb/tb_frame_serializer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/frame_serializer_if.sv
// Handshake/bus bundle between the control logic and the frame serializer.
interface frame_serializer_if #(
  parameter int unsigned MSG_W = 5,
  parameter int unsigned CNT_W = 3
);
  logic             send;
  logic [CNT_W-1:0] cnt;
  logic [MSG_W-1:0] msg;
  logic             ser_out;
  logic             busy;
  logic             done;
  logic             bit_tick;

  modport master (
    output send, cnt, msg,
    input  ser_out, busy, done, bit_tick
  );

  modport slave (
    input  send, cnt, msg,
    output ser_out, busy, done, bit_tick
  );
endinterface

// File: rtl/frame_serializer.sv
// Serializes a message word into preamble/data/[parity]/guard bits for the ASK/FSK modulator.
// Optional even-parity bit after the data is compiled in with FRAME_PARITY_EN.
module frame_serializer #(
  parameter int unsigned MSG_W   = 5,
  parameter int unsigned PRE_LEN = 3,
  parameter int unsigned CNT_W   = 3
) (
  input logic               clk,
  input logic               rst,
  frame_serializer_if.slave bus
);

  localparam int unsigned MAX_LEN = (PRE_LEN > MSG_W) ? PRE_LEN : MSG_W;
  localparam int unsigned IDX_W   = $clog2(MAX_LEN + 1);

`ifdef FRAME_PARITY_EN
  typedef enum logic [2:0] {IDLE, PRE, DATA, PAR, GUARD} state_t;
`else
  typedef enum logic [2:0] {IDLE, PRE, DATA, GUARD} state_t;
`endif

  state_t           state;
  logic             send_q;
  logic [MSG_W-1:0] msg_sh;
  logic [CNT_W-1:0] cnt_l;
  logic [CNT_W-1:0] tick;
  logic [IDX_W-1:0] bit_idx;
  logic [IDX_W-1:0] idx_nxt;
  logic             start_c;
`ifdef FRAME_PARITY_EN
  logic             par;
`endif

  assign idx_nxt = bit_idx + IDX_W'(1);
  assign start_c = bus.send & ~send_q;

  // Frame sequencer: tick counts down the current bit, bit_idx counts bits within a state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      send_q       <= 1'b1;
      msg_sh       <= '0;
      cnt_l        <= '0;
      tick         <= '0;
      bit_idx      <= '0;
`ifdef FRAME_PARITY_EN
      par          <= 1'b0;
`endif
      bus.ser_out  <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.bit_tick <= 1'b0;
    end else begin
      send_q       <= bus.send;
      bus.done     <= 1'b0;
      bus.bit_tick <= 1'b0;

      if (state == IDLE) begin
        bus.ser_out <= 1'b0;
        bus.busy    <= 1'b0;
        if (start_c) begin
          state        <= PRE;
          msg_sh       <= bus.msg;
          cnt_l        <= bus.cnt;
          tick         <= bus.cnt;
          bit_idx      <= '0;
`ifdef FRAME_PARITY_EN
          par          <= ^bus.msg;
`endif
          bus.ser_out  <= 1'b1;
          bus.busy     <= 1'b1;
          bus.bit_tick <= 1'b1;
        end
      end else if (tick != '0) begin
        tick <= tick - CNT_W'(1);
      end else begin
        // Bit boundary: reload the period and present the next bit.
        tick         <= cnt_l;
        bus.bit_tick <= 1'b1;
        case (state)
          PRE: begin
            if (bit_idx == IDX_W'(PRE_LEN - 1)) begin
              state       <= DATA;
              bit_idx     <= '0;
              bus.ser_out <= msg_sh[MSG_W-1];
              msg_sh      <= msg_sh << 1;
            end else begin
              bit_idx     <= idx_nxt;
              bus.ser_out <= ~idx_nxt[0];
            end
          end
          DATA: begin
            if (bit_idx == IDX_W'(MSG_W - 1)) begin
              bit_idx     <= '0;
`ifdef FRAME_PARITY_EN
              state       <= PAR;
              bus.ser_out <= par;
`else
              state       <= GUARD;
              bus.ser_out <= 1'b0;
`endif
            end else begin
              bit_idx     <= idx_nxt;
              bus.ser_out <= msg_sh[MSG_W-1];
              msg_sh      <= msg_sh << 1;
            end
          end
`ifdef FRAME_PARITY_EN
          PAR: begin
            state       <= GUARD;
            bus.ser_out <= 1'b0;
          end
`endif
          GUARD: begin
            state        <= IDLE;
            bus.ser_out  <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
            bus.bit_tick <= 1'b0;
          end
          default: begin
            state        <= IDLE;
            bus.ser_out  <= 1'b0;
            bus.busy     <= 1'b0;
            bus.bit_tick <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_serializer.sv
// Directed, table-driven bench for frame_serializer (both parity and plain builds).
module tb_frame_serializer;

  localparam int unsigned MSG_W   = 5;
  localparam int unsigned PRE_LEN = 3;
  localparam int unsigned CNT_W   = 3;
`ifdef FRAME_PARITY_EN
  localparam int FL = 10;
`else
  localparam int FL = 9;
`endif

  typedef struct {
    logic [CNT_W-1:0] c;
    logic [MSG_W-1:0] m;
    logic [FL-1:0]    bits;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  frame_serializer_if #(.MSG_W(MSG_W), .CNT_W(CNT_W)) bus ();

  frame_serializer #(.MSG_W(MSG_W), .PRE_LEN(PRE_LEN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Checks a whole frame cycle by cycle, then the done cycle. Returns at the done-cycle negedge.
  task automatic run_frame(input logic [CNT_W-1:0] c, input logic [MSG_W-1:0] m,
                           input logic [FL-1:0] bits, input bit pulse, input bit poke,
                           input bit extra_edge);
    bit first;
    if (pulse) begin
      @(negedge clk);
      bus.send = 1'b1;
      bus.cnt  = c;
      bus.msg  = m;
    end
    @(posedge clk);
    first = 1'b1;
    for (int i = 0; i < FL; i++) begin
      for (int j = 0; j <= int'(c); j++) begin
        @(negedge clk);
        chk($sformatf("ser_out bit%0d cyc%0d", i, j), 32'(bus.ser_out), 32'(bits[FL-1-i]));
        chk($sformatf("busy bit%0d cyc%0d", i, j), 32'(bus.busy), 32'd1);
        chk($sformatf("bit_tick bit%0d cyc%0d", i, j), 32'(bus.bit_tick), 32'(j == 0));
        chk($sformatf("done bit%0d cyc%0d", i, j), 32'(bus.done), 32'd0);
        if (first) bus.send = 1'b0;
        first = 1'b0;
        if (poke && i == 1 && j == 0) begin
          bus.cnt = '0;
          bus.msg = ~m;
        end
        if (extra_edge && i == 3 && j == 0) bus.send = 1'b1;
        if (extra_edge && i == 4 && j == 0) bus.send = 1'b0;
      end
    end
    @(negedge clk);
    chk("done pulse", 32'(bus.done), 32'd1);
    chk("busy after frame", 32'(bus.busy), 32'd0);
    chk("ser_out after frame", 32'(bus.ser_out), 32'd0);
    chk("bit_tick after frame", 32'(bus.bit_tick), 32'd0);
  endtask

  vec_t vt[5];

  initial begin
    total = 0;
    bad   = 0;
`ifdef FRAME_PARITY_EN
    vt[0] = '{c: 3'd0, m: 5'b10110, bits: 10'b1011011010};
    vt[1] = '{c: 3'd0, m: 5'b10100, bits: 10'b1011010000};
    vt[2] = '{c: 3'd2, m: 5'b11111, bits: 10'b1011111110};
    vt[3] = '{c: 3'd1, m: 5'b00000, bits: 10'b1010000000};
    vt[4] = '{c: 3'd7, m: 5'b01001, bits: 10'b1010100100};
`else
    vt[0] = '{c: 3'd0, m: 5'b10110, bits: 9'b101101100};
    vt[1] = '{c: 3'd0, m: 5'b10100, bits: 9'b101101000};
    vt[2] = '{c: 3'd2, m: 5'b11111, bits: 9'b101111110};
    vt[3] = '{c: 3'd1, m: 5'b00000, bits: 9'b101000000};
    vt[4] = '{c: 3'd7, m: 5'b01001, bits: 9'b101010010};
`endif

    rst      = 1'b1;
    bus.send = 1'b0;
    bus.cnt  = '0;
    bus.msg  = '0;
    repeat (3) @(negedge clk);
    chk("reset ser_out", 32'(bus.ser_out), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset bit_tick", 32'(bus.bit_tick), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle busy", 32'(bus.busy), 32'd0);

    // Table: each frame with mid-frame cnt/msg changes that must not matter.
    for (int v = 0; v < 5; v++) begin
      run_frame(vt[v].c, vt[v].m, vt[v].bits, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      chk($sformatf("vec%0d idle after done", v), 32'({bus.busy, bus.done}), 32'd0);
    end

    // Ignored edge while busy, then a back-to-back start in the done cycle.
    run_frame(vt[0].c, vt[0].m, vt[0].bits, 1'b1, 1'b0, 1'b1);
    bus.send = 1'b1;
    bus.cnt  = vt[1].c;
    bus.msg  = vt[1].m;
    run_frame(vt[1].c, vt[1].m, vt[1].bits, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b single done", 32'({bus.busy, bus.done}), 32'd0);

    // Reset in the DATA phase, then send held high across reset release.
    @(negedge clk);
    bus.send = 1'b1;
    bus.cnt  = 3'd1;
    bus.msg  = 5'b11111;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus.send = 1'b0;
    end
    chk("pre-reset busy", 32'(bus.busy), 32'd1);
    chk("pre-reset data bit", 32'(bus.ser_out), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset ser_out", 32'(bus.ser_out), 32'd0);
    chk("midreset busy", 32'(bus.busy), 32'd0);
    chk("midreset done", 32'(bus.done), 32'd0);
    bus.send = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("held send no start %0d", k), 32'({bus.busy, bus.done, bus.ser_out}), 32'd0);
    end
    bus.send = 1'b0;
    @(negedge clk);
    chk("still idle", 32'(bus.busy), 32'd0);
    bus.send = 1'b1;
    bus.cnt  = vt[4].c;
    bus.msg  = vt[4].m;
    run_frame(vt[4].c, vt[4].m, vt[4].bits, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
